cp0_ctrl: RTL and testbench

CP0_CTRL -- requirements
Module: cp0_ctrl

---
 rtl/cp0_ctrl.sv | 156 +++++++++++++++
 tb/tb_cp0_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cp0_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_ctrl -- MIPS-style coprocessor 0 for a five-stage pipeline.
//
// Holds SR (12), Cause (13), EPC (14) and PRId (15). It decides in the M stage
// whether an interrupt or a synchronous exception is taken, and then records
// the cause and the return address.
//
// Parameters
//   PRID        value read back from PRId (reg 15)
//   HANDLER_PC  exception entry address, driven on HandlerPC
//
// Ports
//   clk          clock; all state changes on the rising edge
//   reset        synchronous, active-high
//   A1           read register number (mfc0)
//   A2           write register number (mtc0)
//   DIn          mtc0 write data
//   WE           mtc0 write enable (M stage)
//   EXLClr       eret in M stage; clears SR.EXL
//   M_PC         PC of the M-stage instruction
//   M_DelaySlot  the M-stage instruction sits in a branch delay slot
//   M_EXCCode    M-stage exception code, 0 = none
//   HWInt        level-sensitive external interrupt lines
//   Req          exception/interrupt taken this cycle (pipeline flush)
//   HandlerPC    constant HANDLER_PC
//   EPCOut       return address for eret (forwards a same-cycle mtc0 EPC)
//   DOut         read data for register A1
// -----------------------------------------------------------------------------
module cp0_ctrl #(
  parameter logic [31:0] PRID       = 32'h2021_0601,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic        EXLClr,
  input  logic [31:0] M_PC,
  input  logic        M_DelaySlot,
  input  logic [4:0]  M_EXCCode,
  input  logic [5:0]  HWInt,
  output logic        Req,
  output logic [31:0] HandlerPC,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        take;
  logic [31:0] epc_src;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  assign sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
  assign cause_word = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};

  // EXL masks everything: no nested exceptions while in the handler.
  assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req = (M_EXCCode != 5'd0) & ~exl_q;
  assign take    = int_req | exc_req;

  // Reset beats everything, so the flush request is suppressed during reset.
  assign Req       = take & ~reset;
  assign HandlerPC = HANDLER_PC;

  // A delay-slot instruction restarts at its branch, one word earlier.
  assign epc_src = M_DelaySlot ? (M_PC - 32'd4) : M_PC;

  // Forward a same-cycle mtc0 EPC so an eret right behind it sees the new value.
  assign EPCOut = (WE && (A2 == REG_EPC)) ? {DIn[31:2], 2'b00} : epc_q;

  always_comb begin
    case (A1)
      REG_SR:    DOut = sr_word;
      REG_CAUSE: DOut = cause_word;
      REG_EPC:   DOut = epc_q;
      REG_PRID:  DOut = PRID;
      default:   DOut = 32'd0;
    endcase
  end

  // NOTE: every _d gets a default of its _q first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ip_d       = HWInt;  // pending lines are sampled every cycle

    if (take) begin
      // Taking the exception overrides any mtc0 or eret in the same cycle.
      exl_d      = 1'b1;
      bd_d       = M_DelaySlot;
      exc_code_d = int_req ? 5'd0 : M_EXCCode;
      epc_d      = {epc_src[31:2], 2'b00};
    end else begin
      if (WE && (A2 == REG_SR)) begin
        im_d  = DIn[15:10];
        exl_d = DIn[1];
        ie_d  = DIn[0];
      end
      if (WE && (A2 == REG_EPC)) begin
        epc_d = {DIn[31:2], 2'b00};
      end
      // Placed after the SR write so an eret paired with mtc0 SR ends with EXL=0.
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_ctrl -- directed, table-driven bench for cp0_ctrl.
// Each vector is driven after the falling edge. Req, DOut and EPCOut are then
// compared before the next rising edge, so DOut shows the state left by the
// previous vectors.
// -----------------------------------------------------------------------------
module tb_cp0_ctrl;

  localparam logic [31:0] PRID       = 32'h2021_0601;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  logic        clk;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] DIn;
  logic        WE, EXLClr;
  logic [31:0] M_PC;
  logic        M_DelaySlot;
  logic [4:0]  M_EXCCode;
  logic [5:0]  HWInt;
  logic        Req;
  logic [31:0] HandlerPC, EPCOut, DOut;

  int pass_cnt  = 0;
  int total_cnt = 0;

  cp0_ctrl #(.PRID(PRID), .HANDLER_PC(HANDLER_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .A1         (A1),
    .A2         (A2),
    .DIn        (DIn),
    .WE         (WE),
    .EXLClr     (EXLClr),
    .M_PC       (M_PC),
    .M_DelaySlot(M_DelaySlot),
    .M_EXCCode  (M_EXCCode),
    .HWInt      (HWInt),
    .Req        (Req),
    .HandlerPC  (HandlerPC),
    .EPCOut     (EPCOut),
    .DOut       (DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic        clr;
    logic [31:0] pc;
    logic        ds;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        exp_req;
    logic [31:0] exp_dout;
    logic [31:0] exp_epco;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [4:0] a1, logic [4:0] a2,
                              logic [31:0] din, logic we, logic clr,
                              logic [31:0] pc, logic ds, logic [4:0] exc,
                              logic [5:0] hw, logic exp_req,
                              logic [31:0] exp_dout, logic [31:0] exp_epco);
    vec_t v;
    v.rst = rst; v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.clr = clr;
    v.pc = pc; v.ds = ds; v.exc = exc; v.hw = hw;
    v.exp_req = exp_req; v.exp_dout = exp_dout; v.exp_epco = exp_epco;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; A1 = v.a1; A2 = v.a2; DIn = v.din; WE = v.we;
    EXLClr = v.clr; M_PC = v.pc; M_DelaySlot = v.ds; M_EXCCode = v.exc;
    HWInt = v.hw;
    #2;
    check({tag, " req"},    {31'd0, Req}, {31'd0, v.exp_req});
    check({tag, " dout"},   DOut,         v.exp_dout);
    check({tag, " epcout"}, EPCOut,       v.exp_epco);
  endtask

  vec_t vecs[21];

  initial begin
    // Main walk: state carries from one row to the next.
    vecs[0]  = mk(0, 12, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 32'h0, 32'h0);
    // Sync exception, not in delay slot
    vecs[1]  = mk(0, 13, 0, 0, 0, 0, 32'h3008, 0, 4, 0,             1, 32'h0, 32'h0);
    // EXL=1 blocks a second exception
    vecs[2]  = mk(0, 14, 0, 0, 0, 0, 32'h3008, 0, 4, 0,             0, 32'h3008, 32'h3008);
    vecs[3]  = mk(0, 13, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 32'h10, 32'h3008);
    // eret clears EXL
    vecs[4]  = mk(0, 12, 0, 0, 0, 1, 0, 0, 0, 0,                    0, 32'h2, 32'h3008);
    // Delay-slot exception
    vecs[5]  = mk(0, 12, 0, 0, 0, 0, 32'h3010, 1, 10, 0,            1, 32'h0, 32'h3008);
    vecs[6]  = mk(0, 13, 0, 0, 0, 1, 0, 0, 0, 0,                    0, 32'h8000_0028, 32'h300C);
    // mtc0 SR: IM[0]=1, IE=1
    vecs[7]  = mk(0, 14, 12, 32'h401, 1, 0, 0, 0, 0, 0,            0, 32'h300C, 32'h300C);
    // Interrupt beats exception
    vecs[8]  = mk(0, 12, 0, 0, 0, 0, 32'h3020, 0, 12, 6'h01,        1, 32'h401, 32'h300C);
    // EXL blocks all; mtc0 SR with EXL=1 plus eret leaves EXL=0
    vecs[9]  = mk(0, 13, 12, 32'h3, 1, 1, 0, 0, 4, 6'h3F,           0, 32'h400, 32'h3020);
    // IM=0 masks every line
    vecs[10] = mk(0, 12, 0, 0, 0, 0, 0, 0, 0, 6'h3F,                0, 32'h1, 32'h3020);
    // mtc0 EPC forwarding with forced low bits
    vecs[11] = mk(0, 13, 14, 32'h3007, 1, 0, 0, 0, 0, 0,            0, 32'hFC00, 32'h3004);
    // Writes to Cause and PRId are ignored
    vecs[12] = mk(0, 14, 13, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0,       0, 32'h3004, 32'h3004);
    vecs[13] = mk(0, 13, 15, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0,       0, 32'h0, 32'h3004);
    // Req wins over a same-cycle mtc0 EPC; EPC low bits forced
    vecs[14] = mk(0, 15, 14, 32'h5555_0000, 1, 0, 32'h3043, 0, 8, 0, 1, PRID, 32'h5555_0000);
    vecs[15] = mk(0, 14, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 32'h3040, 32'h3040);
    // Reset mid-handler
    vecs[16] = mk(1, 12, 0, 0, 0, 0, 0, 0, 4, 0,                    0, 32'h3, 32'h3040);
    vecs[17] = mk(0, 14, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 32'h0, 32'h0);
    vecs[18] = mk(0, 12, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 32'h0, 32'h0);
    vecs[19] = mk(0, 13, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 32'h0, 32'h0);
    vecs[20] = mk(0, 15, 0, 0, 0, 0, 0, 0, 0, 0,                    0, PRID, 32'h0);

    reset = 1'b1; A1 = '0; A2 = '0; DIn = '0; WE = 1'b0; EXLClr = 1'b0;
    M_PC = '0; M_DelaySlot = 1'b0; M_EXCCode = '0; HWInt = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 21; i++)
      run_vec(vecs[i], $sformatf("v%0d", i));

    check("handler_pc", HandlerPC, HANDLER_PC);

    // Reset takes priority over a pending exception and an mtc0 SR.
    run_vec(mk(1, 12, 12, 32'h401, 1, 0, 32'h3008, 0, 4, 0, 0, 32'h0, 32'h0), "rst_prio");
    run_vec(mk(0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0), "rst_prio_sr");
    run_vec(mk(0, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0), "rst_prio_epc");

    // Delay-slot EPC with an unaligned PC, plus an mtc0 to an unused number.
    run_vec(mk(0, 13, 3, 32'hFFFF_FFFF, 1, 0, 32'h1002, 1, 1, 0, 1, 32'h0, 32'h0), "ds_exc");
    run_vec(mk(0, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFC, 32'hFFC), "ds_epc");
    run_vec(mk(0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0004, 32'hFFC), "ds_cause");
    run_vec(mk(0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2, 32'hFFC), "ds_sr");
    run_vec(mk(0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'hFFC), "unimpl_read");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
